// File: rtl/div_hilo_unit.sv
// div_hilo_unit: multicycle control stage around a combinational unsigned
// divider core. Converts signed operands to magnitudes, holds them on the
// core for LATENCY edges, then sign-corrects the result into HI/LO.
module div_hilo_unit #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_z,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;

  logic [31:0] quot;
  logic [31:0] rem;

  assign quot = div_z[63:32];
  assign rem  = div_z[31:0];

  // Next-state logic: operand capture in IDLE, countdown and result write in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        if (start) begin
          sa_d    = is_signed & op_a[31];
          sb_d    = is_signed & op_b[31];
          div_a_d = sa_d ? -op_a : op_a;
          div_b_d = sb_d ? -op_b : op_b;
          dbz_d   = (op_b == '0);
          cnt_d   = 4'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (dbz_q) begin
            // Original dividend is recovered by re-negating the stored magnitude.
            lo_d = '1;
            hi_d = sa_q ? -div_a_q : div_a_q;
          end else begin
            lo_d = (sa_q ^ sb_q) ? -quot : quot;
            hi_d = sa_q ? -rem : rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign busy        = (state_q == BUSY);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
